chunk_stats: RTL and testbench
==============================

# chunk_stats

Consumer end of the chunk-descriptor queue loaded by the chunker. Pops one (start, end, id) descriptor at a time, reads every sample in the chunk through a single variable-index read port, and accumulates sum and sum of squares. It then produces the integer mean and population variance for that chunk on a valid/ready result port. It runs until the queue drains after a `start`, then pulses `done`.

## Interface
- `DW`, 16: sample width; `var[DW-1:0]` is used, upper bits ignored; samples are unsigned.
- `MAX_N`, 65536: maximum chunk length; larger descriptors are illegal.
- `Clk` in 1: single clock, rising edge.
- `Rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; arms the block to drain the queue.
- `done` out 1: one-cycle pulse when armed, idle, and `q_empty`.
- `q_si` in 32: head descriptor start index.
- `q_ei` in 32: head descriptor end index.
- `q_id` in 32: head descriptor id.
- `q_empty` in 1: queue has no head.
- `q_pop` out 1: one-cycle pop; head is latched in the same cycle.
- `varIndx` out 32: sample index request.
- `var` in 32: sample data, valid exactly 1 cycle after `varIndx`.
- `res_valid` out 1: result valid.
- `res_ready` in 1: result accepted when high with `res_valid`.
- `res_id` out 32: descriptor id of the result.
- `res_mean` out 32: mean, zero-extended from DW bits.
- `res_var` out 32: variance, 2·DW bits.

## Operation
- States: IDLE, POP, FETCH, DIV_MEAN, DIV_VAR, OUT. An `armed` flag is set by `start`.
- **IDLE**
  - armed & !q_empty → POP.
  - armed & q_empty → pulse `done`, clear armed, stay in IDLE.
  - `start` arriving while armed is ignored.
- **POP**
  - Assert `q_pop` and latch `lo=min(si,ei)`, `hi=max(si,ei)`, `n=hi-lo`, id.
  - Descriptors may be ascending or descending.
  - n==0 → OUT with mean 0, var 0, and no reads. Otherwise → FETCH.
- **FETCH**
  - `varIndx` = lo, lo+1, …, hi-1 on consecutive cycles.
  - Each returned sample is added to sum (48b); its square is added to sumsq (64b).
  - After the last sample is accumulated → DIV_MEAN.
- **DIV_MEAN**: mean = floor(sum/n) via divider.
- **DIV_VAR**: var = floor(sumsq/n) − mean². No clamp is needed; the result is always ≥0.
- **OUT**
  - Hold `res_valid` and all result fields stable until `res_ready`.
  - On transfer, return to IDLE; armed is still set, so the next descriptor is popped.
  - `q_pop` is never asserted while a result is pending.
- `varIndx` holds its last value outside FETCH.
- Reset, including mid-operation:
  - All outputs go to 0, state to IDLE, armed clears, accumulators clear.
  - An already popped descriptor is lost.

## Timing
- Reset values: `q_pop`, `done`, `res_valid` = 0; `varIndx`, `res_id`, `res_mean`, `res_var` = 0.
- Cycle numbering takes the POP cycle as 0.
  - FETCH occupies cycles 1..n+1: requests go out in cycles 1..n and the last datum is captured in cycle n+1.
  - DIV_MEAN occupies cycles n+2..n+66: 1 start cycle plus 64 iterations.
  - DIV_VAR occupies cycles n+67..n+131.
  - `res_valid` rises in cycle n+132.
- For n==0, `res_valid` rises in cycle 1.
- `done` is asserted 1 cycle after IDLE observes armed & q_empty.
- `start` and `res_ready` have no combinational path to any output.

## Configuration
- `CHUNK_STATS_VAR_EN` defined: full behaviour as above.
- `CHUNK_STATS_VAR_EN` undefined:
  - The sumsq accumulator, squarer and DIV_VAR state are removed.
  - `res_var` is tied to 0.
  - `res_valid` rises in cycle n+67.

## Structure
- Package `chunk_stats_pkg` holds:
  - State encoding.
  - `SUM_W`=48, `SQ_W`=64, `DIV_CYC`=64.
  - Descriptor field width 32.
- Sub-module `chunk_div`: sequential restoring divider.
  - 64-bit dividend, 32-bit divisor.
  - `go` pulse; `busy`; `q` is valid when `fin` pulses, 64 cycles after `go`.
  - Shared by DIV_MEAN and DIV_VAR.

## Test plan
- Descriptor si=0, ei=4, id=7 with samples 1,2,3,4 → mean 2, var 3 (30/4=7, 7−4), id 7; `res_valid` at cycle 136.
- Descending descriptor si=8, ei=6 with samples 5,5 at indices 6,7 → `varIndx` sequence 6,7; mean 5, var 0.
- Descriptor si=ei=3 → no `varIndx` change; mean 0, var 0; `res_valid` at cycle 1.
- n=2, samples 0xFFFF and 0x1_FFFF (upper bits ignored) → mean 0xFFFF, var 0.
- Hold `res_ready` low 10 cycles with a second descriptor queued → result stable, `q_pop` stays low; the pop follows the transfer.
- Assert `Rst` in the middle of FETCH → all outputs 0 immediately. Then `start` with an empty queue → `done` pulse, no `q_pop`.

Source files
------------

// File: rtl/chunk_stats_pkg.sv
// Shared widths and state encoding for chunk_stats.
// CHUNK_STATS_VAR_EN adds the variance state.
package chunk_stats_pkg;
    localparam int SUM_W   = 48;
    localparam int SQ_W    = 64;
    localparam int DIV_CYC = 64;
    localparam int DESC_W  = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_FETCH,
        S_DIV_MEAN,
`ifdef CHUNK_STATS_VAR_EN
        S_DIV_VAR,
`endif
        S_OUT
    } state_t;
endpackage

// File: rtl/chunk_stats_div.sv
// chunk_div: 64/32 sequential restoring divider, one quotient bit per cycle.
// q is the final quotient in the cycle fin pulses, DIV_CYC cycles after go.
module chunk_div
    import chunk_stats_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        go,
    input  logic [63:0] dvd,
    input  logic [31:0] dvs,
    output logic        busy,
    output logic        fin,
    output logic [63:0] q
);
    logic [63:0] qr;
    logic [31:0] rem, dvs_r;
    logic [6:0]  cnt;
    logic [32:0] rem_sh, rem_sub;
    logic        take;
    logic        unused_msb;

    // remainder stays below the divisor, so the shifted value fits 33 bits
    always_comb begin
        rem_sh  = {rem, qr[63]};
        take    = rem_sh >= {1'b0, dvs_r};
        rem_sub = take ? rem_sh - {1'b0, dvs_r} : rem_sh;
        q       = {qr[62:0], take};
        fin     = busy && (cnt == 7'd1);
    end
    assign unused_msb = rem_sub[32];

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            qr    <= '0;
            rem   <= '0;
            dvs_r <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (go) begin
            qr    <= dvd;
            rem   <= '0;
            dvs_r <= dvs;
            cnt   <= 7'(DIV_CYC);
            busy  <= 1'b1;
        end else if (busy) begin
            qr    <= q;
            rem   <= rem_sub[31:0];
            cnt   <= cnt - 7'd1;
            busy  <= (cnt != 7'd1);
        end
    end
endmodule

// File: rtl/chunk_stats.sv
// chunk_stats: drains the chunk-descriptor queue, producing mean/variance per chunk.
// CHUNK_STATS_VAR_EN enables the sum-of-squares path and variance output.
module chunk_stats
    import chunk_stats_pkg::*;
#(
    parameter int DW    = 16,
    parameter int MAX_N = 65536
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              start,
    output logic              done,
    input  logic [DESC_W-1:0] q_si,
    input  logic [DESC_W-1:0] q_ei,
    input  logic [DESC_W-1:0] q_id,
    input  logic              q_empty,
    output logic              q_pop,
    output logic [31:0]       varIndx,
    input  logic [31:0]       var_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DESC_W-1:0] res_id,
    output logic [31:0]       res_mean,
    output logic [31:0]       res_var
);
    localparam int CNT_W = $clog2(MAX_N + 1);

    state_t            state, nxt;
    logic              armed;
    logic [CNT_W-1:0]  n_r, cnt;
    logic [SUM_W-1:0]  sum;
    logic [DW-1:0]     sample;
    logic [31:0]       lo_c, hi_c, n_c;
    logic              div_go, div_busy, div_fin;
    logic [63:0]       div_dvd, div_q;
    logic              unused_bits;

    assign sample      = var_data[DW-1:0];
    assign q_pop       = (state == S_POP);
    assign res_valid   = (state == S_OUT);
    assign unused_bits = ^{var_data[31:DW], n_c[31:CNT_W], div_q[63:DW]};

`ifdef CHUNK_STATS_VAR_EN
    logic [SQ_W-1:0]   sumsq;
    logic [2*DW-1:0]   sq;
    logic [31:0]       var_r;
    assign sq      = sample * sample;
    assign res_var = var_r;
    assign div_go  = (state == S_DIV_MEAN || state == S_DIV_VAR) && !div_busy;
    assign div_dvd = (state == S_DIV_MEAN) ? {{(64-SUM_W){1'b0}}, sum} : sumsq;
`else
    assign res_var = '0;
    assign div_go  = (state == S_DIV_MEAN) && !div_busy;
    assign div_dvd = {{(64-SUM_W){1'b0}}, sum};
`endif

    always_comb begin
        lo_c = (q_si < q_ei) ? q_si : q_ei;
        hi_c = (q_si < q_ei) ? q_ei : q_si;
        n_c  = hi_c - lo_c;
        nxt  = state;
        case (state)
            S_IDLE:     if (armed && !q_empty) nxt = S_POP;
            S_POP:      nxt = (n_c == 32'd0) ? S_OUT : S_FETCH;
            S_FETCH:    if (cnt == n_r) nxt = S_DIV_MEAN;
`ifdef CHUNK_STATS_VAR_EN
            S_DIV_MEAN: if (div_fin) nxt = S_DIV_VAR;
            S_DIV_VAR:  if (div_fin) nxt = S_OUT;
`else
            S_DIV_MEAN: if (div_fin) nxt = S_OUT;
`endif
            S_OUT:      if (res_ready) nxt = S_IDLE;
            default:    nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= S_IDLE;
            armed    <= 1'b0;
            done     <= 1'b0;
            n_r      <= '0;
            cnt      <= '0;
            sum      <= '0;
            varIndx  <= '0;
            res_id   <= '0;
            res_mean <= '0;
`ifdef CHUNK_STATS_VAR_EN
            sumsq    <= '0;
            var_r    <= '0;
`endif
        end else begin
            state <= nxt;
            done  <= (state == S_IDLE) && armed && q_empty;
            if ((state == S_IDLE) && armed && q_empty) armed <= 1'b0;
            else if (start)                            armed <= 1'b1;
            case (state)
                S_POP: begin
                    n_r    <= n_c[CNT_W-1:0];
                    cnt    <= '0;
                    sum    <= '0;
                    res_id <= q_id;
`ifdef CHUNK_STATS_VAR_EN
                    sumsq  <= '0;
                    if (n_c == 32'd0) var_r <= '0;
`endif
                    if (n_c != 32'd0) varIndx  <= lo_c;
                    else              res_mean <= '0;
                end
                // cnt==k-1 in the k-th FETCH cycle; data trails the request by one
                S_FETCH: begin
                    cnt <= cnt + 1'b1;
                    if (cnt + 1'b1 < n_r) varIndx <= varIndx + 32'd1;
                    if (cnt != '0) begin
                        sum   <= sum + {{(SUM_W-DW){1'b0}}, sample};
`ifdef CHUNK_STATS_VAR_EN
                        sumsq <= sumsq + {{(SQ_W-2*DW){1'b0}}, sq};
`endif
                    end
                end
                S_DIV_MEAN: if (div_fin) res_mean <= {{(32-DW){1'b0}}, div_q[DW-1:0]};
`ifdef CHUNK_STATS_VAR_EN
                S_DIV_VAR:  if (div_fin) var_r <= div_q[31:0] - res_mean * res_mean;
`endif
                default: ;
            endcase
        end
    end

    chunk_div u_div (
        .Clk  (Clk),
        .Rst  (Rst),
        .go   (div_go),
        .dvd  (div_dvd),
        .dvs  ({{(32-CNT_W){1'b0}}, n_r}),
        .busy (div_busy),
        .fin  (div_fin),
        .q    (div_q)
    );
endmodule

// File: tb/tb_chunk_stats.sv
// Scoreboard bench for chunk_stats: descriptor stimulus pushes expectations,
// a negedge monitor checks index sequence, latency, hold-stability and results.
module tb_chunk_stats;
`ifdef CHUNK_STATS_VAR_EN
    localparam int LAT = 132;
`else
    localparam int LAT = 67;
`endif

    typedef struct {
        logic [31:0] id, mean, vr;
        int          lo, n, lat;
    } exp_t;

    logic        Clk = 1'b0, Rst = 1'b1, start = 1'b0, res_ready = 1'b1;
    logic        done, q_pop, res_valid, q_empty;
    logic [31:0] q_si, q_ei, q_id, varIndx, var_data, res_id, res_mean, res_var;

    logic [31:0] mem [64];
    logic [31:0] d_si [16], d_ei [16], d_id [16];
    logic [3:0]  wp = '0, rp = '0;
    exp_t        exp_q [$];
    int          total = 0, bad = 0, cyc = 0;

    chunk_stats dut (
        .Clk(Clk), .Rst(Rst), .start(start), .done(done),
        .q_si(q_si), .q_ei(q_ei), .q_id(q_id), .q_empty(q_empty), .q_pop(q_pop),
        .varIndx(varIndx), .var_data(var_data),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_mean(res_mean), .res_var(res_var)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // queue head and one-cycle-latency sample memory
    assign q_empty = (wp == rp);
    assign q_si    = d_si[rp];
    assign q_ei    = d_ei[rp];
    assign q_id    = d_id[rp];
    always @(posedge Clk) if (q_pop) rp <= rp + 4'd1;
    always @(posedge Clk) var_data <= mem[varIndx[5:0]];

    function automatic void check(string name, logic [63:0] act, logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endfunction

    function automatic logic [31:0] ev(logic [31:0] v);
`ifdef CHUNK_STATS_VAR_EN
        return v;
`else
        return (v & 32'h0);
`endif
    endfunction

    task automatic push_desc(input int si, input int ei, input int id,
                             input int mean, input int vr);
        exp_t e;
        int   n;
        n = (si > ei) ? si - ei : ei - si;
        d_si[wp] = si; d_ei[wp] = ei; d_id[wp] = id;
        wp = wp + 4'd1;
        e.id = id; e.mean = mean; e.vr = ev(vr);
        e.lo = (si < ei) ? si : ei; e.n = n;
        e.lat = (n == 0) ? 1 : n + LAT;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        @(posedge Clk); #1 start = 1'b1;
        @(posedge Clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge Clk);
            if (done) break;
        end
        if (k == budget) check(tag, done, 1);
    endtask

    // monitor
    int          chk_lo = 0, chk_n = 0, chk_k = 0, pop_cyc = 0;
    bit          chk_zero = 0, prev_v = 0, prev_rdy = 0;
    logic [31:0] chk_hold = '0, h_id = '0, h_mean = '0, h_var = '0;

    always @(negedge Clk) begin
        if (!Rst) begin
            chk_n = 0; chk_k = 0; chk_zero = 0; prev_v = 0;
        end else begin
            if (chk_k < chk_n) begin
                check("varIndx_seq", varIndx, chk_lo + chk_k);
                chk_k++;
            end else if (chk_zero) begin
                check("varIndx_hold", varIndx, chk_hold);
                chk_zero = 0;
            end
            if (q_pop) begin
                if (exp_q.size() == 0) check("unexpected_pop", q_pop, 0);
                else begin
                    chk_lo = exp_q[0].lo; chk_n = exp_q[0].n; chk_k = 0;
                    chk_zero = (exp_q[0].n == 0); chk_hold = varIndx; pop_cyc = cyc;
                end
            end
            if (res_valid) check("pop_while_pending", q_pop, 0);
            if (res_valid && !prev_v) begin
                if (exp_q.size() == 0) check("unexpected_result", res_valid, 0);
                else check("latency", cyc - pop_cyc, exp_q[0].lat);
            end
            if (res_valid && prev_v && !prev_rdy) begin
                check("hold_id", res_id, h_id);
                check("hold_mean", res_mean, h_mean);
                check("hold_var", res_var, h_var);
            end
            if (res_valid && res_ready && exp_q.size() != 0) begin
                check("res_id", res_id, exp_q[0].id);
                check("res_mean", res_mean, exp_q[0].mean);
                check("res_var", res_var, exp_q[0].vr);
                void'(exp_q.pop_front());
            end
            prev_v = res_valid; prev_rdy = res_ready;
            h_id = res_id; h_mean = res_mean; h_var = res_var;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[0] = 1; mem[1] = 2; mem[2] = 3; mem[3] = 4;
        mem[6] = 5; mem[7] = 5;
        mem[10] = 32'h0000_FFFF; mem[11] = 32'h0001_FFFF;

        #2 Rst = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_q_pop", q_pop, 0);
        check("rst_done", done, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_varIndx", varIndx, 0);
        check("rst_res_id", res_id, 0);
        check("rst_res_mean", res_mean, 0);
        check("rst_res_var", res_var, 0);
        @(posedge Clk); #1 Rst = 1'b1;

        // ascending, descending, empty, and wide-sample descriptors
        push_desc(0, 4, 7, 2, 3);
        push_desc(8, 6, 8, 5, 0);
        push_desc(3, 3, 9, 0, 0);
        push_desc(10, 12, 10, 32'hFFFF, 0);
        pulse_start();
        wait_done(3000, "batch1_done_timeout");
        check("batch1_drained", exp_q.size(), 0);

        // back-pressure with a second descriptor waiting
        res_ready = 1'b0;
        push_desc(0, 2, 11, 1, 1);
        push_desc(6, 8, 12, 5, 0);
        pulse_start();
        for (k = 0; k < 500; k++) begin
            @(negedge Clk);
            if (res_valid) break;
        end
        if (k == 500) check("bp_valid_timeout", res_valid, 1);
        repeat (10) @(negedge Clk);
        @(posedge Clk); #1 res_ready = 1'b1;
        wait_done(1000, "batch2_done_timeout");
        check("batch2_drained", exp_q.size(), 0);

        // reset in the middle of FETCH
        push_desc(40, 20, 13, 0, 0);
        pulse_start();
        for (k = 0; k < 100; k++) begin
            @(negedge Clk);
            if (q_pop) break;
        end
        if (k == 100) check("rst_pop_timeout", q_pop, 1);
        repeat (3) @(negedge Clk);
        @(posedge Clk); #1 Rst = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_q_pop", q_pop, 0);
        check("midrst_done", done, 0);
        check("midrst_res_valid", res_valid, 0);
        check("midrst_varIndx", varIndx, 0);
        check("midrst_res_id", res_id, 0);
        check("midrst_res_mean", res_mean, 0);
        check("midrst_res_var", res_var, 0);
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b1;
        repeat (2) @(posedge Clk);

        // start on an empty queue: done two cycles after start is sampled
        pulse_start();
        for (k = 1; k <= 20; k++) begin
            @(negedge Clk);
            check("empty_no_pop", q_pop, 0);
            if (done) break;
        end
        check("empty_done_latency", k, 2);
        @(negedge Clk);
        check("done_one_cycle", done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
